// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ==========================================================================
// Package : alu_seq_pkg
// Brief   : Op-codes, sequencer FSM states and the ALU reference function.
// Rev     : 1.0
// ==========================================================================
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } seq_state_e;

  // Returns {carry, result, zero}; carry is forced 0 for the logic ops.
  function automatic logic [5:0] alu_expect(input logic [2:0] op,
                                            input logic [3:0] a,
                                            input logic [3:0] b);
    logic [4:0] wide;
    logic [3:0] res;
    logic       cy;
    wide = 5'd0;
    res  = 4'd0;
    cy   = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        res  = wide[3:0];
        cy   = wide[4];
      end
      OP_SUB: begin
        wide = {1'b0, a} - {1'b0, b};
        res  = wide[3:0];
        cy   = wide[4];
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      default: res = ~(a ^ b);
    endcase
    return {cy, res, (res == 4'd0)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_fifo.sv
`default_nettype none
// ==========================================================================
// Module : alu_seq_fifo
// Brief  : Synchronous command FIFO, power-of-2 depth, show-ahead read port.
// Rev    : 1.0
// ==========================================================================
module alu_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ==========================================================================
// Module : alu_op_sequencer
// Brief  : Queues ALU commands, issues them to a registered 4-bit ALU and
//          returns result/carry/zero/tag on a valid/ready response channel.
//          Optional self-check model: ALU_OP_SEQUENCER_CHECK_EN.
// Rev    : 1.0
// ==========================================================================
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_control,
  input  logic [3:0]       alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_mismatch,
  output logic             busy
);

  localparam int CMD_W = 3 + 4 + 4 + TAG_W;

  seq_state_e       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [3:0]       rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_rdata;
  logic             carry_masked;

  assign fifo_push = cmd_valid && !fifo_full;
  assign cmd_ready = !fifo_full;

  alu_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({cmd_op, cmd_a, cmd_b, cmd_tag}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The ALU keeps a stale carry on logic ops, so only ADD/SUB pass it through.
  assign carry_masked = (op_q[2:1] == 2'b00) && alu_carry;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    tag_d        = tag_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_tag_d    = rsp_tag_q;
    fifo_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = CAPT;
      CAPT: begin
        rsp_result_d = alu_result;
        rsp_carry_d  = carry_masked;
        rsp_zero_d   = alu_zero;
        rsp_tag_d    = tag_q;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (fifo_pop) {op_d, a_d, b_d, tag_d} = fifo_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      tag_q        <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      tag_q        <= tag_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_tag_q    <= rsp_tag_d;
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_control = op_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_result  = rsp_result_q;
  assign rsp_carry   = rsp_carry_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_tag     = rsp_tag_q;
  assign busy        = (state_q != IDLE) || !fifo_empty;

`ifdef ALU_OP_SEQUENCER_CHECK_EN
  logic [5:0] model_w;
  logic       mismatch_q, mismatch_d;

  assign model_w = alu_expect(op_q, a_q, b_q);

  always_comb begin
    mismatch_d = mismatch_q;
    if (state_q == CAPT) mismatch_d = (model_w != {carry_masked, alu_result, alu_zero});
  end

  always_ff @(posedge clk) begin
    if (rst) mismatch_q <= 1'b0;
    else     mismatch_q <= mismatch_d;
  end

  assign rsp_mismatch = mismatch_q;
`else
  assign rsp_mismatch = 1'b0;
`endif

endmodule
`default_nettype wire
